// File: rtl/sig_weight_twos_pkg.sv
// Shared constants and elaboration-time helpers for the weight/complement/sigmoid slice.
// The sigmoid table generator uses integer fixed-point only, so any tool can evaluate it.
package sig_weight_twos_pkg;

  localparam int DW           = 16;
  localparam int NUM_WEIGHT   = 3;
  localparam int SIG_IN_WIDTH = 10;
  localparam int SIG_IN_FRAC  = 5;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // Entry for table address addr (x = addr - 2^(in_w-1)).
  // e^(-|v|) is built as (e^(-s))^(2^k) with s <= 1 so the series stays in [0,1] (Q60).
  function automatic logic [127:0] sigmoid_entry(input int unsigned addr, input int dw,
                                                 input int in_w, input int in_frac);
    logic [127:0] one_q;
    logic [127:0] s_q;
    logic [127:0] term;
    logic [127:0] e_q;
    logic [127:0] num;
    logic [127:0] den;
    logic [127:0] val;
    logic [127:0] limit;
    int           signed_x;
    int           mag;
    signed_x = int'(addr) - (1 << (in_w - 1));
    mag      = (signed_x < 0) ? -signed_x : signed_x;
    one_q    = 128'd1 << 60;
    s_q      = 128'(mag) << (61 - in_w);
    term     = one_q;
    e_q      = one_q;
    for (int n = 1; n < 30; n++) begin
      term = ((term * s_q) >> 60) / 128'(n);
      if ((n % 2) == 1) e_q = e_q - term;
      else              e_q = e_q + term;
    end
    for (int k = 0; k < (in_w - 1 - in_frac); k++) begin
      e_q = (e_q * e_q) >> 60;
    end
    // Negative v uses e^v/(1+e^v) so nothing ever exceeds 1.0.
    num   = (signed_x < 0) ? e_q : one_q;
    den   = one_q + e_q;
    val   = ((num << dw) + den) / (den << 1);
    limit = (128'd1 << (dw - 1)) - 128'd1;
    if (val > limit) val = limit;
    return val;
  endfunction

endpackage

// File: rtl/sig_weight_twos_if.sv
// Bus bundle for sig_weight_twos: weight memory, two's complementer and sigmoid lookup.
interface sig_weight_twos_if
  import sig_weight_twos_pkg::*;
#(
  parameter int dataWidth    = DW,
  parameter int addressWidth = clog2(NUM_WEIGHT),
  parameter int sigInWidth   = SIG_IN_WIDTH
);

  logic                      wen;
  logic [addressWidth-1:0]   wadd;
  logic [dataWidth-1:0]      win;
  logic                      ren;
  logic [addressWidth:0]     radd;
  logic [dataWidth-1:0]      wout;
  logic                      sign;
  logic [2*dataWidth-2:0]    i_multOut;
  logic [2*dataWidth-1:0]    muxOut;
  logic [sigInWidth-1:0]     x;
  logic [dataWidth-1:0]      out;

  modport master (
    output wen, wadd, win, ren, radd, sign, i_multOut, x,
    input  wout, muxOut, out
  );

  modport slave (
    input  wen, wadd, win, ren, radd, sign, i_multOut, x,
    output wout, muxOut, out
  );

endinterface

// File: rtl/sig_weight_twos_sigmoid_lut.sv
// Constant sigmoid ROM with a registered lookup; address is x with its MSB flipped.
module sigmoid_lut
  import sig_weight_twos_pkg::*;
#(
  parameter int dataWidth  = DW,
  parameter int sigInWidth = SIG_IN_WIDTH,
  parameter int sigInFrac  = SIG_IN_FRAC
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [sigInWidth-1:0] x,
  output logic [dataWidth-1:0]  out
);

  localparam int DEPTH = 1 << sigInWidth;

  logic [dataWidth-1:0]  table_rom [DEPTH];
  logic [sigInWidth-1:0] table_addr;

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    localparam logic [127:0] ENTRY = sigmoid_entry(a, dataWidth, sigInWidth, sigInFrac);
    assign table_rom[a] = ENTRY[dataWidth-1:0];
  end

  assign table_addr = {~x[sigInWidth-1], x[sigInWidth-2:0]};

  always_ff @(posedge clk) begin
    if (!rst) out <= '0;
    else      out <= table_rom[table_addr];
  end

endmodule

// File: rtl/sig_weight_twos.sv
// Neuron helper slice: sign-magnitude weight store, product two's complementer, sigmoid table.
// The three paths share only clock and reset.
module sig_weight_twos
  import sig_weight_twos_pkg::*;
#(
  parameter int dataWidth    = DW,
  parameter int numWeight    = NUM_WEIGHT,
  parameter int addressWidth = clog2(numWeight),
  parameter int sigInWidth   = SIG_IN_WIDTH,
  parameter int sigInFrac    = SIG_IN_FRAC
) (
  input  logic               clk,
  input  logic               rst,
  sig_weight_twos_if.slave   bus
);

  localparam logic [addressWidth:0] NUM_ADDR = (addressWidth + 1)'(numWeight);

  logic [dataWidth-1:0]   mem [numWeight];
  logic [2*dataWidth-1:0] mag_ext;

  // Memory contents survive reset; unwritten words rely on zero power-up state.
  always_ff @(posedge clk) begin
    if (bus.wen && ({1'b0, bus.wadd} < NUM_ADDR)) mem[bus.wadd] <= bus.win;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.wout <= '0;
    end else if (bus.ren) begin
      bus.wout <= (bus.radd < NUM_ADDR) ? mem[bus.radd[addressWidth-1:0]] : '0;
    end
  end

  assign mag_ext = {1'b0, bus.i_multOut};

  always_ff @(posedge clk) begin
    if (!rst)          bus.muxOut <= '0;
    else if (bus.sign) bus.muxOut <= -mag_ext;
    else               bus.muxOut <= mag_ext;
  end

  sigmoid_lut #(
    .dataWidth (dataWidth),
    .sigInWidth(sigInWidth),
    .sigInFrac (sigInFrac)
  ) u_lut (
    .clk(clk),
    .rst(rst),
    .x  (bus.x),
    .out(bus.out)
  );

endmodule

// File: tb/tb_sig_weight_twos.sv
// Directed bench for sig_weight_twos: arithmetic reference model checked every cycle,
// plus hand-computed literal expectations at key points.
module tb_sig_weight_twos;

  localparam int DWT = 16;
  localparam int NW  = 3;
  localparam int AW  = 2;
  localparam int SW  = 10;
  localparam int SF  = 5;

  logic clk = 1'b0;
  logic rst;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  logic [DWT-1:0]   model_mem [NW];
  logic [DWT-1:0]   exp_wout;
  logic [2*DWT-1:0] exp_mux;
  logic [DWT-1:0]   exp_out;

  sig_weight_twos_if #(.dataWidth(DWT), .addressWidth(AW), .sigInWidth(SW)) bus ();

  sig_weight_twos #(
    .dataWidth(DWT), .numWeight(NW), .addressWidth(AW), .sigInWidth(SW), .sigInFrac(SF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic logic [DWT-1:0] sigmoid_ref(input logic [SW-1:0] xv);
    real v;
    real s;
    int  r;
    v = real'($signed(xv)) / real'(1 << SF);
    s = real'(1 << (DWT - 1)) / (1.0 + $exp(-v));
    r = int'(s);
    if (r > (1 << (DWT - 1)) - 1) r = (1 << (DWT - 1)) - 1;
    return DWT'(r);
  endfunction

  // Reference behaviour: reads see memory before this edge's write.
  always @(posedge clk) begin
    longint m;
    if (!rst) begin
      exp_wout = '0;
      exp_mux  = '0;
      exp_out  = '0;
      model_on = 1'b1;
    end else begin
      if (bus.ren) exp_wout = (int'(bus.radd) < NW) ? model_mem[bus.radd[AW-1:0]] : '0;
      m = longint'(bus.i_multOut);
      if (bus.sign) m = ((longint'(1) << (2 * DWT)) - m) % (longint'(1) << (2 * DWT));
      exp_mux = m[2*DWT-1:0];
      exp_out = sigmoid_ref(bus.x);
    end
    if (bus.wen && int'(bus.wadd) < NW) model_mem[bus.wadd] = bus.win;
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      checkOutput("model wout", 64'(bus.wout), 64'(exp_wout));
      checkOutput("model muxOut", 64'(bus.muxOut), 64'(exp_mux));
      checkOutput("model out", 64'(bus.out), 64'(exp_out));
    end
  end

  task automatic applyStimulus(input logic r, input logic we, input logic [AW-1:0] wa,
                               input logic [DWT-1:0] wi, input logic re, input logic [AW:0] ra,
                               input logic sg, input logic [2*DWT-2:0] mo,
                               input logic [SW-1:0] xv);
    rst           = r;
    bus.wen       = we;
    bus.wadd      = wa;
    bus.win       = wi;
    bus.ren       = re;
    bus.radd      = ra;
    bus.sign      = sg;
    bus.i_multOut = mo;
    bus.x         = xv;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkAll(input string tag, input logic [63:0] ew, input logic [63:0] em,
                          input logic [63:0] eo);
    checkOutput({tag, " wout"}, 64'(bus.wout), ew);
    checkOutput({tag, " muxOut"}, 64'(bus.muxOut), em);
    checkOutput({tag, " out"}, 64'(bus.out), eo);
  endtask

  initial begin
    for (int i = 0; i < NW; i++) model_mem[i] = '0;

    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 31'd15, 10'd5);
    checkAll("reset", 64'h0, 64'h0, 64'h0);

    applyStimulus(1'b1, 1'b1, 2'd0, 16'h0005, 1'b0, 3'd0, 1'b0, 31'd15, 10'h000);
    checkAll("step2", 64'h0, 64'h0000_000F, 64'd16384);

    applyStimulus(1'b1, 1'b1, 2'd1, 16'h8003, 1'b0, 3'd0, 1'b1, 31'd15, 10'h020);
    checkAll("step3", 64'h0, 64'hFFFF_FFF1, 64'd23955);

    applyStimulus(1'b1, 1'b1, 2'd2, 16'h7FFF, 1'b0, 3'd0, 1'b1, 31'd0, 10'h3E0);
    checkAll("step4", 64'h0, 64'h0, 64'd8813);

    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 3'd0, 1'b1, 31'h7FFF_FFFF, 10'h200);
    checkAll("read0", 64'h0005, 64'h8000_0001, 64'd0);

    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 31'd0, 10'h1FF);
    checkAll("read1", 64'h8003, 64'h0, 64'd32767);

    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 31'd0, 10'h000);
    checkOutput("read2 wout", 64'(bus.wout), 64'h7FFF);

    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 3'd3, 1'b0, 31'd0, 10'h000);
    checkOutput("read3 wout", 64'(bus.wout), 64'h0);

    applyStimulus(1'b1, 1'b1, 2'd1, 16'h1234, 1'b1, 3'd1, 1'b0, 31'd0, 10'h000);
    checkOutput("read-first wout", 64'(bus.wout), 64'h8003);

    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 3'd1, 1'b0, 31'd0, 10'h000);
    checkOutput("reread1 wout", 64'(bus.wout), 64'h1234);

    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 1'b0, 3'd0, 1'b0, 31'd0, 10'h000);
    checkOutput("hold wout", 64'(bus.wout), 64'h1234);

    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 1'b1, 3'd2, 1'b0, 31'd99, 10'h020);
    checkAll("mid reset", 64'h0, 64'h0, 64'h0);

    applyStimulus(1'b1, 1'b0, 2'd0, 16'h0000, 1'b1, 3'd1, 1'b1, 31'd1, 10'h020);
    checkAll("post reset", 64'h1234, 64'hFFFF_FFFF, 64'd23955);

    // Sweep x across the table with mixed writes, reads and signs; the model checks each edge.
    for (int i = 0; i < 28; i++) begin
      applyStimulus(1'b1, (i % 4) == 0, 2'(i % 3), 16'(i * 1111), 1'b1, 3'(i % 5),
                    (i % 3) == 1, 31'(i * 76543217), 10'(i * 37 - 512));
    end

    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
